// File: rtl/instr_sequencer.sv
// Fetch/execute controller for tinycpu: fetches an instruction byte, decodes it and
// drives every datapath strobe and mux select. Optional single-step gating: TINYCPU_SSTEP_EN.
module instr_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack,
    input  logic [7:0] rA,
    input  logic       step,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_ctrl,
    output logic [2:0] mux_ctrl_rA,
    output logic       mux_ctrl_rB,
    output logic [1:0] mux_ctrl_rM,
    output logic       ld_rA,
    output logic       ld_rB,
    output logic       ld_rM,
    output logic       ld_rP,
    output logic       inc_rP,
    output logic [7:0] rA_ldi,
    output logic [3:0] alu_op,
    output logic       halted,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_EXEC      = 3'd1,
        S_MEM       = 3'd2,
        S_HALT      = 3'd3,
        S_STEP_WAIT = 3'd4
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ALU  = 4'h2;
    localparam logic [3:0] OP_SWAB = 4'h3;
    localparam logic [3:0] OP_SWMB = 4'h4;
    localparam logic [3:0] OP_CPPA = 4'h5;
    localparam logic [3:0] OP_CPPM = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] RA_SRC_LDI = 3'd0;
    localparam logic [2:0] RA_SRC_ALU = 3'd1;
    localparam logic [2:0] RA_SRC_RB  = 3'd2;
    localparam logic [2:0] RA_SRC_RP  = 3'd3;
    localparam logic [2:0] RA_SRC_DQ  = 3'd4;
    localparam logic       RB_SRC_RA  = 1'b0;
    localparam logic       RB_SRC_RM  = 1'b1;
    localparam logic [1:0] RM_SRC_RB  = 2'd1;
    localparam logic [1:0] RM_SRC_RP  = 2'd2;

    // With single-step enabled, every completed instruction parks in STEP_WAIT.
`ifdef TINYCPU_SSTEP_EN
    localparam state_t RESET_STATE = S_STEP_WAIT;
    localparam state_t DONE_STATE  = S_STEP_WAIT;
`else
    localparam state_t RESET_STATE = S_FETCH;
    localparam state_t DONE_STATE  = S_FETCH;
    logic step_unused;
    assign step_unused = step;
`endif

    state_t     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic       illegal_q, illegal_d;
    logic [3:0] op;

    assign op     = ir_q[7:4];
    assign rA_ldi = {4'h0, ir_q[3:0]};
    assign alu_op = ir_q[3:0];
    assign illegal = illegal_q;
    assign halted  = (state_q == S_HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RESET_STATE;
            ir_q      <= 8'h00;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op)
                    OP_LD, OP_ST: state_d = S_MEM;
                    OP_HALT:      state_d = S_HALT;
                    4'hB, 4'hC, 4'hD, 4'hE: begin
                        illegal_d = 1'b1;
                        state_d   = DONE_STATE;
                    end
                    default:      state_d = DONE_STATE;
                endcase
            end
            S_MEM: begin
                if (mem_ack) begin
                    state_d = DONE_STATE;
                end
            end
            S_HALT: state_d = S_HALT;
`ifdef TINYCPU_SSTEP_EN
            S_STEP_WAIT: begin
                if (step) begin
                    state_d = S_FETCH;
                end
            end
`endif
            default: state_d = RESET_STATE;
        endcase
    end

    // Strobes are combinational from state; rst overrides everything so an
    // in-flight transfer (including an ST write) is dropped immediately.
    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        addr_ctrl   = 1'b0;
        mux_ctrl_rA = RA_SRC_LDI;
        mux_ctrl_rB = RB_SRC_RA;
        mux_ctrl_rM = 2'd0;
        ld_rA       = 1'b0;
        ld_rB       = 1'b0;
        ld_rM       = 1'b0;
        ld_rP       = 1'b0;
        inc_rP      = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    inc_rP  = mem_ack;
                end
                S_EXEC: begin
                    case (op)
                        OP_LDI: begin
                            ld_rA       = 1'b1;
                            mux_ctrl_rA = RA_SRC_LDI;
                        end
                        OP_ALU: begin
                            ld_rA       = 1'b1;
                            mux_ctrl_rA = RA_SRC_ALU;
                        end
                        OP_SWAB: begin
                            ld_rA       = 1'b1;
                            ld_rB       = 1'b1;
                            mux_ctrl_rA = RA_SRC_RB;
                            mux_ctrl_rB = RB_SRC_RA;
                        end
                        OP_SWMB: begin
                            ld_rM       = 1'b1;
                            ld_rB       = 1'b1;
                            mux_ctrl_rM = RM_SRC_RB;
                            mux_ctrl_rB = RB_SRC_RM;
                        end
                        OP_CPPA: begin
                            ld_rA       = 1'b1;
                            mux_ctrl_rA = RA_SRC_RP;
                        end
                        OP_CPPM: begin
                            ld_rM       = 1'b1;
                            mux_ctrl_rM = RM_SRC_RP;
                        end
                        OP_JMP:  ld_rP = 1'b1;
                        OP_JZ:   ld_rP = (rA == 8'h00);
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_req   = 1'b1;
                    addr_ctrl = 1'b1;
                    mem_we    = (op == OP_ST);
                    if (mem_ack && op == OP_LD) begin
                        ld_rA       = 1'b1;
                        mux_ctrl_rA = RA_SRC_DQ;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
